hsi_m_rx_sched: RTL and testbench
=================================

# hsi_m_rx_sched

Receive-side transaction scheduler for the HSI master. It sits above the master RX control path and sequences each response frame. After every transmitted request it opens a response window and supervises the start-bit and frame-end timeouts. It checks the error vector, fails over between the redundant lines dat1/dat2, and issues bounded repeat requests to the service-request controller.

## Interface
Parameters:
- RETRY_MAX, 3: repeat requests allowed per transaction before failure is declared (1..7)
- TMO_W, 16: timeout counter width

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- clk_en  in  1  bit-rate tick; timers advance only when high
- tx_done  in  1  1-cycle pulse: a request frame has been fully transmitted
- tmo_start  in  TMO_W  ticks allowed from tx_done to start bit
- tmo_frame  in  TMO_W  ticks allowed from start bit to frame end
- rx_start_bit_accepted  in  1  pulse from decoder
- rx_frame_end  in  1  pulse from decoder
- rx_errs  in  6  error vector from error checker; valid the cycle after rx_frame_end
- stat_clr  in  1  synchronous clear of line error counters
- dat_src  out  1  line select: 1 = dat1, 0 = dat2
- dpr_repeat_req  out  1  1-cycle repeat request pulse
- rst_service_req_ctrl  out  1  1-cycle pulse clearing the service-request controller
- xfer_ok  out  1  1-cycle pulse: response received clean
- xfer_fail  out  1  1-cycle pulse: retries exhausted
- busy  out  1  high in every state except IDLE
- retry_cnt  out  3  retries used in current transaction
- err_cnt1, err_cnt2  out  8 each  saturating error counters for dat1 / dat2

## Operation
- FSM states: IDLE, WAIT_START, RECEIVE, CHECK.
- IDLE:
  - On tx_done, load the timer with tmo_start.
  - Pulse rst_service_req_ctrl in the same cycle.
  - Go to WAIT_START.
- WAIT_START:
  - The timer decrements on clk_en.
  - rx_start_bit_accepted loads the timer with tmo_frame and moves to RECEIVE.
  - A timer reaching 0 on a clk_en cycle is an error.
- RECEIVE:
  - rx_frame_end moves to CHECK.
  - Timer expiry is an error.
- CHECK (exactly one cycle): samples rx_errs.
  - rx_errs == 0: pulse xfer_ok, clear retry_cnt, go to IDLE.
  - rx_errs != 0: error.
- Error handling (timeout or rx_errs != 0):
  - Increment the error counter of the currently selected line; it saturates at 255.
  - If retry_cnt < RETRY_MAX: retry_cnt++, toggle dat_src, pulse dpr_repeat_req, go to IDLE and await the next tx_done.
  - Otherwise: pulse xfer_fail, clear retry_cnt, keep dat_src, go to IDLE.
- Timer loaded with 0 expires on the first clk_en tick.
- tx_done outside IDLE aborts the current window without an error count:
  - reload tmo_start, go to WAIT_START;
  - retry_cnt is kept;
  - rst_service_req_ctrl pulses.
- stat_clr zeroes both error counters. If stat_clr and an increment occur in the same cycle, the clear wins.

## Timing
- Reset values:
  - state IDLE, dat_src 1, retry_cnt 0, err_cnt1/err_cnt2 0;
  - every pulse output 0, busy 0.
- All outputs are registered.
- rst_service_req_ctrl asserts the cycle after tx_done.
- xfer_ok, xfer_fail and dpr_repeat_req assert the cycle after CHECK, or the cycle after the timeout tick.
- Simultaneous events:
  - Start bit and timer expiry in the same cycle: start bit wins.
  - Frame end and timer expiry in the same cycle: frame end wins.
- dat_src changes only together with the dpr_repeat_req pulse, never mid-frame.
- Reset asserted mid-transaction returns all state to reset values immediately.

## Structure
- Shared package hsi_pkg holds:
  - the state enum;
  - RX_ERR_W = 6;
  - the default RETRY_MAX;
  - line encodings LINE_DAT1 = 1, LINE_DAT2 = 0.
- One sub-module, hsi_rx_timer: loadable down-counter with clk_en, load value, load strobe and expired flag.
- The FSM, retry logic and statistics stay in the top module.

## Test plan
- tx_done; start after 5 ticks; frame_end; rx_errs = 0 -> one xfer_ok pulse, retry_cnt 0, dat_src stays 1, busy low after CHECK.
- tx_done, tmo_start = 10, no start bit -> err_cnt1 = 1, dpr_repeat_req pulse on tick 10, dat_src = 0, retry_cnt = 1.
- Four consecutive failures with RETRY_MAX = 3 -> three dpr_repeat_req pulses (dat_src toggling), then xfer_fail, retry_cnt 0, err_cnt1 = 2, err_cnt2 = 2.
- Start bit and timer expiry in the same cycle -> enters RECEIVE, no error counted; frame_end with timer expiry -> CHECK.
- rx_errs = 6'b000100 after frame_end -> repeat request, retry_cnt 1; a clean retry then gives xfer_ok with retry_cnt 0.
- 300 forced errors on dat1 -> err_cnt1 saturates at 255; stat_clr together with an error -> counter reads 0; n_rst low in RECEIVE -> all outputs at reset values.

Source files
------------

// File: rtl/hsi_pkg.sv
// Shared definitions for the HSI master receive scheduler: FSM states,
// error-vector width, retry default and line encodings.
package hsi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_CHECK
    } rx_state_t;

    localparam int RX_ERR_W      = 6;
    localparam int RETRY_MAX_DEF = 3;

    localparam logic LINE_DAT1 = 1'b1;
    localparam logic LINE_DAT2 = 1'b0;

    // Line error statistics stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hsi_rx_timer.sv
// Loadable bit-rate down-counter used for the start-bit and frame-end windows.
// expired flags the tick on which the count reaches (or already sits at) zero.
module hsi_rx_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clk_en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clk_en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A count of 1 hits zero on this tick; a count of 0 means the window was empty.
    assign expired = clk_en && (count <= W'(1));

endmodule

// File: rtl/hsi_m_rx_sched.sv
// Receive-side transaction scheduler: supervises the response window after each
// request, checks the error vector, fails over between dat1/dat2 and bounds retries.
module hsi_m_rx_sched
    import hsi_pkg::*;
#(
    parameter int RETRY_MAX = RETRY_MAX_DEF,
    parameter int TMO_W     = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clk_en,
    input  logic                tx_done,
    input  logic [TMO_W-1:0]    tmo_start,
    input  logic [TMO_W-1:0]    tmo_frame,
    input  logic                rx_start_bit_accepted,
    input  logic                rx_frame_end,
    input  logic [RX_ERR_W-1:0] rx_errs,
    input  logic                stat_clr,
    output logic                dat_src,
    output logic                dpr_repeat_req,
    output logic                rst_service_req_ctrl,
    output logic                xfer_ok,
    output logic                xfer_fail,
    output logic                busy,
    output logic [2:0]          retry_cnt,
    output logic [7:0]          err_cnt1,
    output logic [7:0]          err_cnt2
);

    rx_state_t        state, state_nx;
    logic [2:0]       retry_nx;
    logic             dat_src_nx;
    logic             ok_nx, fail_nx, dpr_nx, rsr_nx;
    logic             err_event;
    logic             tmr_load, tmr_expired;
    logic [TMO_W-1:0] tmr_val;

    hsi_rx_timer #(.W(TMO_W)) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clk_en   (clk_en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= ST_IDLE;
            retry_cnt            <= '0;
            dat_src              <= LINE_DAT1;
            xfer_ok              <= 1'b0;
            xfer_fail            <= 1'b0;
            dpr_repeat_req       <= 1'b0;
            rst_service_req_ctrl <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            state                <= state_nx;
            retry_cnt            <= retry_nx;
            dat_src              <= dat_src_nx;
            xfer_ok              <= ok_nx;
            xfer_fail            <= fail_nx;
            dpr_repeat_req       <= dpr_nx;
            rst_service_req_ctrl <= rsr_nx;
            busy                 <= (state_nx != ST_IDLE);
        end
    end

    // A new tx_done always restarts the window, even mid-response, and is not an error.
    always_comb begin
        state_nx   = state;
        retry_nx   = retry_cnt;
        dat_src_nx = dat_src;
        ok_nx      = 1'b0;
        fail_nx    = 1'b0;
        dpr_nx     = 1'b0;
        rsr_nx     = 1'b0;
        err_event  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = tmo_start;

        if (tx_done) begin
            tmr_load = 1'b1;
            tmr_val  = tmo_start;
            rsr_nx   = 1'b1;
            state_nx = ST_WAIT_START;
        end else begin
            case (state)
                ST_WAIT_START: begin
                    if (rx_start_bit_accepted) begin
                        tmr_load = 1'b1;
                        tmr_val  = tmo_frame;
                        state_nx = ST_RECEIVE;
                    end else if (tmr_expired) begin
                        err_event = 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    if (rx_frame_end) begin
                        state_nx = ST_CHECK;
                    end else if (tmr_expired) begin
                        err_event = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (rx_errs == '0) begin
                        ok_nx    = 1'b1;
                        retry_nx = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Retry on the other line until the budget is spent, then give up on this line.
        if (err_event) begin
            state_nx = ST_IDLE;
            if (retry_cnt < 3'(RETRY_MAX)) begin
                retry_nx   = retry_cnt + 3'd1;
                dat_src_nx = ~dat_src;
                dpr_nx     = 1'b1;
            end else begin
                retry_nx = '0;
                fail_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_cnt1 <= '0;
            err_cnt2 <= '0;
        end else if (stat_clr) begin
            err_cnt1 <= '0;
            err_cnt2 <= '0;
        end else if (err_event) begin
            if (dat_src == LINE_DAT1) begin
                err_cnt1 <= sat_inc(err_cnt1);
            end else begin
                err_cnt2 <= sat_inc(err_cnt2);
            end
        end
    end

endmodule

// File: tb/tb_hsi_m_rx_sched.sv
// Scoreboard bench for hsi_m_rx_sched: directed transactions push the expected
// outcome, a negedge monitor pops and compares on every result pulse.
module tb_hsi_m_rx_sched;

    localparam int K_OK   = 0;
    localparam int K_FAIL = 1;
    localparam int K_REP  = 2;

    typedef struct {
        int         kind;
        bit         full;
        logic [2:0] retry;
        logic       ds;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic        clk_en;
    logic        tx_done;
    logic [15:0] tmo_start;
    logic [15:0] tmo_frame;
    logic        rx_start_bit_accepted;
    logic        rx_frame_end;
    logic [5:0]  rx_errs;
    logic        stat_clr;
    logic        dat_src;
    logic        dpr_repeat_req;
    logic        rst_service_req_ctrl;
    logic        xfer_ok;
    logic        xfer_fail;
    logic        busy;
    logic [2:0]  retry_cnt;
    logic [7:0]  err_cnt1;
    logic [7:0]  err_cnt2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    hsi_m_rx_sched #(.RETRY_MAX(3), .TMO_W(16)) dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .clk_en                (clk_en),
        .tx_done               (tx_done),
        .tmo_start             (tmo_start),
        .tmo_frame             (tmo_frame),
        .rx_start_bit_accepted (rx_start_bit_accepted),
        .rx_frame_end          (rx_frame_end),
        .rx_errs               (rx_errs),
        .stat_clr              (stat_clr),
        .dat_src               (dat_src),
        .dpr_repeat_req        (dpr_repeat_req),
        .rst_service_req_ctrl  (rst_service_req_ctrl),
        .xfer_ok               (xfer_ok),
        .xfer_fail             (xfer_fail),
        .busy                  (busy),
        .retry_cnt             (retry_cnt),
        .err_cnt1              (err_cnt1),
        .err_cnt2              (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input bit full, input int retry,
                        input int ds, input int e1, input int e2);
        exp_t e;
        e.kind  = kind;
        e.full  = full;
        e.retry = 3'(retry);
        e.ds    = 1'(ds);
        e.e1    = 8'(e1);
        e.e2    = 8'(e2);
        sb.push_back(e);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && (xfer_ok || xfer_fail || dpr_repeat_req)) begin
            int   act_kind;
            exp_t e;
            if (int'(xfer_ok) + int'(xfer_fail) + int'(dpr_repeat_req) > 1) act_kind = 3;
            else if (xfer_ok)   act_kind = K_OK;
            else if (xfer_fail) act_kind = K_FAIL;
            else                act_kind = K_REP;
            if (sb.size() == 0) begin
                check_output("unexpected_pulse_kind", act_kind, -1);
            end else begin
                e = sb.pop_front();
                check_output("pulse_kind", act_kind, e.kind);
                if (e.full) begin
                    check_output("retry_cnt", retry_cnt, e.retry);
                    check_output("dat_src", dat_src, e.ds);
                    check_output("err_cnt1", err_cnt1, e.e1);
                    check_output("err_cnt2", err_cnt2, e.e2);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_dat_src"}, dat_src, 1);
        check_output({tag, "_retry_cnt"}, retry_cnt, 0);
        check_output({tag, "_err_cnt1"}, err_cnt1, 0);
        check_output({tag, "_err_cnt2"}, err_cnt2, 0);
        check_output({tag, "_pulses"},
                     {dpr_repeat_req, rst_service_req_ctrl, xfer_ok, xfer_fail}, 0);
        check_output({tag, "_busy"}, busy, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        idle(2);
        check_reset_values("reset");
        n_rst = 1'b1;
        idle(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            clk_en = 1'b1;
            idle(1);
            clk_en = 1'b0;
            idle(1);
        end
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        idle(1);
        tx_done = 1'b0;
    endtask

    task automatic pulse_start();
        rx_start_bit_accepted = 1'b1;
        idle(1);
        rx_start_bit_accepted = 1'b0;
    endtask

    task automatic pulse_end();
        rx_frame_end = 1'b1;
        idle(1);
        rx_frame_end = 1'b0;
    endtask

    // Four timeouts in a row: retry 1..3 alternate the line, the fourth fails.
    int fail_kind[4]  = '{K_REP, K_REP, K_REP, K_FAIL};
    int fail_retry[4] = '{1, 2, 3, 0};
    int fail_ds[4]    = '{0, 1, 0, 0};
    int fail_e1[4]    = '{1, 1, 2, 2};
    int fail_e2[4]    = '{0, 1, 1, 2};

    task automatic apply_stimulus();
        // Clean transaction.
        apply_reset();
        tmo_start = 16'd20;
        tmo_frame = 16'd20;
        rx_errs   = 6'd0;
        pulse_tx();
        check_output("rsr_after_tx", rst_service_req_ctrl, 1);
        check_output("busy_wait_start", busy, 1);
        idle(1);
        check_output("rsr_one_cycle", rst_service_req_ctrl, 0);
        ticks(5);
        pulse_start();
        ticks(2);
        push(K_OK, 1, 0, 1, 0, 0);
        pulse_end();
        idle(1);
        check_output("busy_after_check", busy, 0);
        idle(2);

        // Start-bit timeout exactly on tick 10.
        apply_reset();
        tmo_start = 16'd10;
        pulse_tx();
        ticks(9);
        push(K_REP, 1, 1, 0, 1, 0);
        ticks(1);
        idle(2);

        // Retry budget exhaustion.
        apply_reset();
        tmo_start = 16'd2;
        for (int i = 0; i < 4; i++) begin
            pulse_tx();
            push(fail_kind[i], 1, fail_retry[i], fail_ds[i], fail_e1[i], fail_e2[i]);
            ticks(2);
        end
        idle(2);

        // Start bit vs expiry, then frame end vs expiry.
        apply_reset();
        tmo_start = 16'd3;
        tmo_frame = 16'd2;
        pulse_tx();
        ticks(2);
        clk_en = 1'b1;
        rx_start_bit_accepted = 1'b1;
        idle(1);
        clk_en = 1'b0;
        rx_start_bit_accepted = 1'b0;
        check_output("busy_in_receive", busy, 1);
        check_output("no_err_on_start_race", err_cnt1, 0);
        ticks(1);
        push(K_OK, 1, 0, 1, 0, 0);
        clk_en = 1'b1;
        rx_frame_end = 1'b1;
        idle(1);
        clk_en = 1'b0;
        rx_frame_end = 1'b0;
        idle(3);

        // Error vector then clean retry.
        apply_reset();
        tmo_start = 16'd20;
        tmo_frame = 16'd20;
        rx_errs = 6'b000100;
        pulse_tx();
        ticks(1);
        pulse_start();
        ticks(1);
        push(K_REP, 1, 1, 0, 1, 0);
        pulse_end();
        idle(2);
        rx_errs = 6'd0;
        pulse_tx();
        pulse_start();
        push(K_OK, 1, 0, 0, 1, 0);
        pulse_end();
        idle(2);

        // Saturation with zero-length windows, then clear-vs-increment.
        apply_reset();
        tmo_start = 16'd0;
        for (int i = 0; i < 600; i++) begin
            pulse_tx();
            push((i % 4 == 3) ? K_FAIL : K_REP, 0, 0, 0, 0, 0);
            ticks(1);
        end
        check_output("err_cnt1_saturated", err_cnt1, 255);
        check_output("err_cnt2_saturated", err_cnt2, 255);
        check_output("dat_src_after_bulk", dat_src, 1);
        check_output("retry_after_bulk", retry_cnt, 0);
        pulse_tx();
        push(K_REP, 1, 1, 0, 0, 0);
        clk_en = 1'b1;
        stat_clr = 1'b1;
        idle(1);
        clk_en = 1'b0;
        stat_clr = 1'b0;
        idle(1);
        pulse_tx();
        push(K_REP, 1, 2, 1, 0, 1);
        ticks(1);

        // Reset asserted while receiving.
        tmo_start = 16'd20;
        pulse_tx();
        pulse_start();
        ticks(1);
        check_output("busy_before_reset", busy, 1);
        n_rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        idle(2);
        n_rst = 1'b1;
        idle(2);
    endtask

    initial begin
        n_rst = 1'b0;
        clk_en = 1'b0;
        tx_done = 1'b0;
        tmo_start = 16'd0;
        tmo_frame = 16'd0;
        rx_start_bit_accepted = 1'b0;
        rx_frame_end = 1'b0;
        rx_errs = 6'd0;
        stat_clr = 1'b0;
        idle(1);
        apply_stimulus();
        idle(4);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
